// File: rtl/jk_conv_sequencer_if.sv
// Control/status and bank-drive bundle between the bring-up controller,
// the JK-conversion sequencer and the flip-flop bank under test.
interface jk_conv_sequencer_if #(
    parameter int STEP_W = 8,
    parameter int CNT_W  = 8
) ();
    logic              start;
    logic [STEP_W-1:0] num_steps;
    logic [7:0]        seed;
    logic              j;
    logic              k;
    logic              dut_reset;
    logic              qsr;
    logic              qb;
    logic              qd;
    logic              qt;
    logic              busy;
    logic              done;
    logic              pass;
    logic [2:0]        err_flags;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [STEP_W-1:0] step_cnt;

    // Sequencer side
    modport slave (
        input  start, num_steps, seed, qsr, qb, qd, qt,
        output j, k, dut_reset, busy, done, pass, err_flags, mismatch_cnt, step_cnt
    );

    // Controller/bank side
    modport master (
        output start, num_steps, seed, qsr, qb, qd, qt,
        input  j, k, dut_reset, busy, done, pass, err_flags, mismatch_cnt, step_cnt
    );
endinterface

// File: rtl/jk_conv_sequencer.sv
// Drives a pseudo-random J/K stream into the JK-conversion bank and checks the
// SR, D and T implementations each cycle against a golden JK model.
module jk_conv_sequencer #(
    parameter int STEP_W    = 8,
    parameter int CNT_W     = 8,
    parameter int CLEAR_CYC = 2
) (
    input logic                clk,
    input logic                reset,
    jk_conv_sequencer_if.slave bus
);
    localparam int CLR_W = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYC - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [CLR_W-1:0]  clr_cnt;
    logic [STEP_W-1:0] num_lat;
    logic [STEP_W-1:0] step_r;
    logic [7:0]        lfsr;
    logic [7:0]        lfsr_nxt;
    logic              j_r, k_r, dut_reset_r;
    logic              busy_r, done_r, pass_r;
    logic              g, g_nxt;
    logic              cmp_en;
    logic [2:0]        mis;
    logic [2:0]        err_r, err_nxt;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt;

    always_comb begin
        g_nxt = g;
        case ({j_r, k_r})
            2'b00:   g_nxt = g;
            2'b01:   g_nxt = 1'b0;
            2'b10:   g_nxt = 1'b1;
            default: g_nxt = ~g;
        endcase

        mis = 3'b000;
        if (cmp_en)
            mis = {bus.qt != g, bus.qd != g, (bus.qsr != g) || (bus.qb == g)};

        err_nxt = err_r | mis;
        cnt_nxt = cnt_r;
        if ((|mis) && (cnt_r != '1))
            cnt_nxt = cnt_r + CNT_W'(1);

        // x^8+x^6+x^5+x^4+1, Fibonacci form
        lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            clr_cnt     <= '0;
            num_lat     <= '0;
            step_r      <= '0;
            lfsr        <= 8'h01;
            j_r         <= 1'b0;
            k_r         <= 1'b0;
            dut_reset_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            g           <= 1'b0;
            cmp_en      <= 1'b0;
            err_r       <= '0;
            cnt_r       <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= err_nxt;
            cnt_r  <= cnt_nxt;
            // compare lands one cycle after the bank captures the drive
            cmp_en <= (state == CLEAR) || (state == RUN);
            if (state == CLEAR || state == RUN || state == DRAIN)
                g <= g_nxt;

            case (state)
                IDLE: begin
                    j_r         <= 1'b0;
                    k_r         <= 1'b0;
                    dut_reset_r <= 1'b1;
                    if (bus.start) begin
                        num_lat     <= bus.num_steps;
                        lfsr        <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
                        err_r       <= '0;
                        cnt_r       <= '0;
                        step_r      <= '0;
                        pass_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        clr_cnt     <= '0;
                        k_r         <= 1'b1;
                        dut_reset_r <= 1'b0;
                        state       <= CLEAR;
                    end
                end

                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        dut_reset_r <= 1'b1;
                        if (num_lat == '0) begin
                            j_r   <= 1'b0;
                            k_r   <= 1'b0;
                            state <= DRAIN;
                        end else begin
                            j_r   <= lfsr[0];
                            k_r   <= lfsr[1];
                            lfsr  <= lfsr_nxt;
                            state <= RUN;
                        end
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end

                RUN: begin
                    step_r <= step_r + STEP_W'(1);
                    if (step_r == num_lat - STEP_W'(1)) begin
                        j_r   <= 1'b0;
                        k_r   <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        j_r  <= lfsr[0];
                        k_r  <= lfsr[1];
                        lfsr <= lfsr_nxt;
                    end
                end

                DRAIN: begin
                    // fold in the final compare happening at this edge
                    pass_r <= (cnt_nxt == '0) && (err_nxt == 3'b000);
                    done_r <= 1'b1;
                    state  <= DONE;
                end

                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.j            = j_r;
    assign bus.k            = k_r;
    assign bus.dut_reset    = dut_reset_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.pass         = pass_r;
    assign bus.err_flags    = err_r;
    assign bus.mismatch_cnt = cnt_r;
    assign bus.step_cnt     = step_r;
endmodule

// File: tb/tb_jk_conv_sequencer.sv
// Bench: behavioural JK bank with fault hooks, stimulus pushes expected drive
// and end-of-run results into queues, independent monitors pop and compare.
module tb_jk_conv_sequencer;
    localparam int STEP_W    = 8;
    localparam int CNT_W     = 4;
    localparam int CLEAR_CYC = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    jk_conv_sequencer_if #(.STEP_W(STEP_W), .CNT_W(CNT_W)) bus ();

    jk_conv_sequencer #(.STEP_W(STEP_W), .CNT_W(CNT_W), .CLEAR_CYC(CLEAR_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic jk_f(input logic q, input logic jj, input logic kk);
        case ({jj, kk})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    // Bank: SR version has no reset, D/T versions use dut_reset synchronously
    logic b_sr = 1'b0, b_d = 1'b0, b_t = 1'b0;
    logic fault_qt = 1'b0, fault_qb = 1'b0;
    always @(posedge clk) begin
        b_sr <= jk_f(b_sr, bus.j, bus.k);
        b_d  <= !bus.dut_reset ? 1'b0 : jk_f(b_d, bus.j, bus.k);
        b_t  <= !bus.dut_reset ? 1'b0 : (b_t ^ ((bus.j & ~b_t) | (bus.k & b_t)));
    end
    assign bus.qsr = b_sr;
    assign bus.qb  = fault_qb ? b_sr : ~b_sr;
    assign bus.qd  = b_d;
    assign bus.qt  = fault_qt ? 1'b0 : b_t;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] v;      // {busy, dut_reset, j, k}
    } drv_exp_t;

    typedef struct {
        int                cyc;
        logic              pass;
        logic [2:0]        err;
        logic [CNT_W-1:0]  cnt;
        logic [STEP_W-1:0] step;
    } res_exp_t;

    drv_exp_t drv_q[$];
    res_exp_t res_q[$];
    drv_exp_t drv_e;
    res_exp_t res_e;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive monitor
    always @(negedge clk) begin
        while (drv_q.size() > 0 && drv_q[0].cyc < cyc) begin
            drv_e = drv_q.pop_front();
            chk("drive_missed", cyc, drv_e.cyc);
        end
        if (drv_q.size() > 0 && drv_q[0].cyc == cyc) begin
            drv_e = drv_q.pop_front();
            chk("drive", {bus.busy, bus.dut_reset, bus.j, bus.k}, drv_e.v);
        end
    end

    // Result monitor
    always @(negedge clk) begin
        if (bus.done) begin
            if (res_q.size() == 0) begin
                chk("done_unexpected", bus.done, 1'b0);
            end else begin
                res_e = res_q.pop_front();
                chk("done_cycle", cyc, res_e.cyc);
                chk("pass", bus.pass, res_e.pass);
                chk("err_flags", bus.err_flags, res_e.err);
                chk("mismatch_cnt", bus.mismatch_cnt, res_e.cnt);
                chk("step_cnt", bus.step_cnt, res_e.step);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Push expectations for a run started at the next edge, then pulse start
    task automatic issue(input logic [7:0] sd, input int n);
        int s;
        logic [7:0] l;
        logic g;
        logic jj, kk;
        int mm;
        logic [2:0] ef;
        drv_exp_t d;
        res_exp_t r;
        s  = cyc;
        l  = (sd == 8'h00) ? 8'h01 : sd;
        g  = 1'b0;
        mm = 0;
        ef = 3'b000;
        for (int i = 1; i <= CLEAR_CYC; i++) begin
            d.cyc = s + i; d.v = 4'b1001; drv_q.push_back(d);
            if (fault_qb) begin mm++; ef[0] = 1'b1; end
        end
        for (int i = 0; i < n; i++) begin
            jj = l[0]; kk = l[1];
            d.cyc = s + CLEAR_CYC + 1 + i; d.v = {2'b11, jj, kk}; drv_q.push_back(d);
            g = jk_f(g, jj, kk);
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
            if (fault_qb || (fault_qt && g)) begin
                mm++;
                if (fault_qb) ef[0] = 1'b1;
                if (fault_qt && g) ef[2] = 1'b1;
            end
        end
        d.cyc = s + CLEAR_CYC + n + 1; d.v = 4'b1100; drv_q.push_back(d);
        d.cyc = s + CLEAR_CYC + n + 2; d.v = 4'b1100; drv_q.push_back(d);
        d.cyc = s + CLEAR_CYC + n + 3; d.v = 4'b0100; drv_q.push_back(d);
        r.cyc  = s + CLEAR_CYC + n + 2;
        r.pass = (mm == 0);
        r.err  = ef;
        r.cnt  = (mm > (2**CNT_W - 1)) ? {CNT_W{1'b1}} : CNT_W'(mm);
        r.step = STEP_W'(n);
        res_q.push_back(r);
        bus.num_steps = STEP_W'(n);
        bus.seed      = sd;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while ((res_q.size() != 0 || drv_q.size() != 0) && t < budget) begin
            tick();
            t++;
        end
        chk("timeout_pending", res_q.size() + drv_q.size(), 0);
        chk("idle_busy", bus.busy, 1'b0);
    endtask

    int s0;

    initial begin
        bus.start     = 1'b0;
        bus.num_steps = '0;
        bus.seed      = '0;

        // Reset then idle
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_drive", {bus.busy, bus.dut_reset, bus.j, bus.k}, 4'b0000);
        chk("rst_done", bus.done, 1'b0);
        reset = 1'b1;
        tick();
        chk("idle_drive", {bus.busy, bus.dut_reset, bus.j, bus.k}, 4'b0100);
        chk("idle_status", {bus.done, bus.pass, bus.err_flags}, 5'b0);
        chk("idle_counts", {bus.mismatch_cnt, bus.step_cnt}, '0);

        // Clean run
        issue(8'hA5, 20);
        wait_done(100);
        chk("pass_hold", bus.pass, 1'b1);

        // qt stuck-at-0, short and long runs
        fault_qt = 1'b1;
        issue(8'hC3, 12);
        wait_done(100);
        issue(8'h01, 50);
        wait_done(200);
        fault_qt = 1'b0;

        // Zero steps, seed 0
        issue(8'h00, 0);
        wait_done(50);

        // qb tied to qsr, saturating counter, ignored start while busy
        fault_qb = 1'b1;
        s0 = cyc;
        issue(8'h5A, 255);
        while (cyc < s0 + CLEAR_CYC + 10) tick();
        bus.num_steps = 8'd3;
        bus.seed      = 8'h77;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        wait_done(400);
        fault_qb = 1'b0;

        // Reset mid-run at step 7, then a normal run with seed 0
        s0 = cyc;
        issue(8'h3C, 20);
        while (cyc < s0 + CLEAR_CYC + 7) tick();
        drv_q.delete();
        res_q.delete();
        reset = 1'b0;
        tick();
        chk("midrst_drive", {bus.busy, bus.dut_reset, bus.j, bus.k}, 4'b0000);
        chk("midrst_status", {bus.done, bus.pass, bus.err_flags}, 5'b0);
        chk("midrst_counts", {bus.mismatch_cnt, bus.step_cnt}, '0);
        tick();
        reset = 1'b1;
        repeat (30) tick();
        chk("midrst_no_restart", bus.busy, 1'b0);
        issue(8'h00, 12);
        wait_done(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
